snoop_multicast: RTL and testbench
==================================

# snoop_multicast

Snoop fan-out/fan-in block for the coherent interconnect. It accepts one snoop request (AC) from the interconnect and broadcasts it to `NoMst` snooped caches. It merges their snoop responses (CR) into one upstream response and forwards the cache-line data (CD) of exactly one data-supplying cache, draining all others. It generalises the single-link snoop bus to N downstream links with ordering and merge behaviour.

## Interface
- `NoMst`, 4: number of snooped caches; at least 1.
- `AddrWidth`, 64: AC address width.
- `DataWidth`, 64: CD data width.
- `clk_i` in 1: clock; the only clock.
- `rst_i` in 1: reset, synchronous, active-high.
- `slv_ac_addr_i` in AddrWidth, `slv_ac_prot_i` in 3, `slv_ac_snoop_i` in 4: upstream snoop request.
- `slv_ac_valid_i` in 1, `slv_ac_ready_o` out 1: upstream AC handshake.
- `slv_cr_resp_o` out 5: merged response in `snoop_pkg::resp_t` encoding. Bits: [0] DataTransfer, [1] Error, [2] PassDirty, [3] IsShared, [4] WasUnique.
- `slv_cr_valid_o` out 1, `slv_cr_ready_i` in 1: upstream CR handshake.
- `slv_cd_data_o` out DataWidth, `slv_cd_last_o` out 1: upstream snoop data.
- `slv_cd_valid_o` out 1, `slv_cd_ready_i` in 1: upstream CD handshake.
- `mst_ac_addr_o` out AddrWidth, `mst_ac_prot_o` out 3, `mst_ac_snoop_o` out 4: broadcast request, shared by all caches.
- `mst_ac_valid_o` out NoMst, `mst_ac_ready_i` in NoMst: per-cache AC handshake.
- `mst_cr_resp_i` in NoMst×5, `mst_cr_valid_i` in NoMst, `mst_cr_ready_o` out NoMst: per-cache CR.
- `mst_cd_data_i` in NoMst×DataWidth, `mst_cd_last_i` in NoMst, `mst_cd_valid_i` in NoMst, `mst_cd_ready_o` out NoMst: per-cache CD.

## Operation
- FSM states: IDLE, BCAST, COLLECT, RESP, DATA. One snoop is in flight at a time.
- **IDLE**
  - `slv_ac_ready_o`=1.
  - On `slv_ac_valid_i`: register addr, prot and snoop; clear `ac_done`, `cr_done` and `dt` masks; go to BCAST.
- **BCAST**
  - `mst_ac_valid_o[i]` = !`ac_done[i]`.
  - Each handshake sets `ac_done[i]`. Caches may accept in any order and cycle.
  - When `ac_done` is all-ones (including in the cycle of the final handshake), go to COLLECT.
- **COLLECT**
  - `mst_cr_ready_o[i]` = !`cr_done[i]`.
  - On handshake: store the response, set `cr_done[i]`, and set `dt[i]` = resp[0].
  - When all are done, go to RESP.
- **RESP**
  - `slv_cr_resp_o` = bitwise OR of all stored responses. Registered; stable while valid.
  - `slv_cr_valid_o`=1 until `slv_cr_ready_i`.
  - On handshake: go to DATA if any `dt`, else IDLE.
- **DATA**
  - `sel` = lowest index with `dt` set.
  - The selected cache's CD is passed through combinationally to the upstream CD port: `slv_cd_valid_o`=`mst_cd_valid_i[sel]` and `mst_cd_ready_o[sel]`=`slv_cd_ready_i`.
  - Every other cache with `dt` set is drained: `mst_cd_ready_o`=1 until its `last` beat; its data is discarded.
  - A cache's `dt` bit clears on its `last` handshake. When `dt` reaches zero, go to IDLE.
- Caches without DataTransfer get `mst_cd_ready_o`=0 throughout.
- Caches with `dt` clear whose CD valid is high are ignored.
- Downstream caches must not make the CR handshake depend on the CD handshake. CD is accepted only in DATA.
- If `NoMst`=1, the block degenerates to a store-and-forward snoop link with the same state sequence.

## Timing
- Reset: after a clock edge with `rst_i`=1, the FSM is in IDLE and all masks are cleared.
  - All valid/ready outputs are 0, except `slv_ac_ready_o`=1.
  - `slv_cr_resp_o`=0; addr, prot, snoop, data and last outputs are 0.
- Reset asserted mid-transaction aborts the snoop at the next edge. No partial CR or CD is emitted afterwards.
- Minimum latencies:
  - Upstream AC handshake to `mst_ac_valid_o`: 1 cycle.
  - Last downstream AC handshake to `mst_cr_ready_o`: 1 cycle.
  - Last CR handshake to `slv_cr_valid_o`: 1 cycle.
  - Upstream CR handshake to DATA entry: 1 cycle.
  - CD pass-through latency: 0 cycles.
- The last CD `last` handshake returns the FSM to IDLE. A new AC is accepted one cycle later.
- All upstream outputs are held stable while valid and not ready; assertion-checkable.
- Simultaneous events:
  - All caches accepting AC in the same cycle counts as one completion.
  - The `last` beats of the selected and drained caches may complete in the same cycle.

## Test plan
- NoMst=4, all caches ready immediately, all resp=5'b00000 → upstream CR=0 exactly once; no CD; back in IDLE; second snoop accepted.
- Cache 2 resp=5'b01001 (IsShared, DataTransfer) sending 4 beats, others 5'b00000 → CR=5'b01001; 4 beats of cache 2 data forwarded with `last` on beat 4.
- Caches 1 and 3 both resp=5'b00101 (PassDirty, DataTransfer) → CR=5'b00101; cache 1's data forwarded; cache 3's 4 beats drained and invisible upstream.
- Caches accept AC in reverse order, one per cycle, and cache 0 stalls CR for 10 cycles → CR emitted 1 cycle after cache 0's CR; `mst_ac_valid_o` never reasserts for a cache that already accepted.
- `slv_cr_ready_i` and `slv_cd_ready_i` toggled randomly → CR and CD payload stable while stalled; the beat count and values seen upstream match the selected cache.
- `rst_i` pulsed during DATA after beat 2 → all outputs at reset values after the edge; the next snoop completes normally.

Source files
------------

// File: rtl/snoop_multicast_if.sv
// Bundled snoop channels of snoop_multicast: one upstream AC/CR/CD link and
// NoMst downstream links that share the broadcast AC payload.
interface snoop_multicast_if #(
  parameter int NoMst     = 4,
  parameter int AddrWidth = 64,
  parameter int DataWidth = 64
);
  logic [AddrWidth-1:0]            slv_ac_addr_i;
  logic [2:0]                      slv_ac_prot_i;
  logic [3:0]                      slv_ac_snoop_i;
  logic                            slv_ac_valid_i;
  logic                            slv_ac_ready_o;
  logic [4:0]                      slv_cr_resp_o;
  logic                            slv_cr_valid_o;
  logic                            slv_cr_ready_i;
  logic [DataWidth-1:0]            slv_cd_data_o;
  logic                            slv_cd_last_o;
  logic                            slv_cd_valid_o;
  logic                            slv_cd_ready_i;
  logic [AddrWidth-1:0]            mst_ac_addr_o;
  logic [2:0]                      mst_ac_prot_o;
  logic [3:0]                      mst_ac_snoop_o;
  logic [NoMst-1:0]                mst_ac_valid_o;
  logic [NoMst-1:0]                mst_ac_ready_i;
  logic [NoMst-1:0][4:0]           mst_cr_resp_i;
  logic [NoMst-1:0]                mst_cr_valid_i;
  logic [NoMst-1:0]                mst_cr_ready_o;
  logic [NoMst-1:0][DataWidth-1:0] mst_cd_data_i;
  logic [NoMst-1:0]                mst_cd_last_i;
  logic [NoMst-1:0]                mst_cd_valid_i;
  logic [NoMst-1:0]                mst_cd_ready_o;

  // Block side
  modport slave (
    input  slv_ac_addr_i, slv_ac_prot_i, slv_ac_snoop_i, slv_ac_valid_i,
    output slv_ac_ready_o,
    output slv_cr_resp_o, slv_cr_valid_o,
    input  slv_cr_ready_i,
    output slv_cd_data_o, slv_cd_last_o, slv_cd_valid_o,
    input  slv_cd_ready_i,
    output mst_ac_addr_o, mst_ac_prot_o, mst_ac_snoop_o, mst_ac_valid_o,
    input  mst_ac_ready_i,
    input  mst_cr_resp_i, mst_cr_valid_i,
    output mst_cr_ready_o,
    input  mst_cd_data_i, mst_cd_last_i, mst_cd_valid_i,
    output mst_cd_ready_o
  );

  // Interconnect and cache side
  modport master (
    output slv_ac_addr_i, slv_ac_prot_i, slv_ac_snoop_i, slv_ac_valid_i,
    input  slv_ac_ready_o,
    input  slv_cr_resp_o, slv_cr_valid_o,
    output slv_cr_ready_i,
    input  slv_cd_data_o, slv_cd_last_o, slv_cd_valid_o,
    output slv_cd_ready_i,
    input  mst_ac_addr_o, mst_ac_prot_o, mst_ac_snoop_o, mst_ac_valid_o,
    output mst_ac_ready_i,
    output mst_cr_resp_i, mst_cr_valid_i,
    input  mst_cr_ready_o,
    output mst_cd_data_i, mst_cd_last_i, mst_cd_valid_i,
    input  mst_cd_ready_o
  );
endinterface

// File: rtl/snoop_multicast.sv
// Snoop fan-out/fan-in: broadcast one AC to NoMst caches, OR-merge their CR,
// forward the lowest data-supplying cache's CD and drain the rest.
module snoop_multicast_lane (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       clr,
  input  logic       in_bcast,
  input  logic       in_collect,
  input  logic       in_data,
  input  logic       fwd,
  input  logic       up_cd_ready,
  input  logic       ac_ready,
  input  logic       cr_valid,
  input  logic [4:0] cr_resp,
  input  logic       cd_valid,
  input  logic       cd_last,
  output logic       ac_valid,
  output logic       cr_ready,
  output logic       cd_ready,
  output logic       ac_done_d,
  output logic       cr_done_d,
  output logic       dt,
  output logic       dt_d,
  output logic [4:0] resp_d
);
  logic       ac_done, cr_done, cr_hs;
  logic [4:0] resp_q;

  assign ac_valid  = in_bcast & ~ac_done;
  assign cr_ready  = in_collect & ~cr_done;
  // Selected lane follows upstream ready; other data lanes are drained freely
  assign cd_ready  = in_data & dt & (fwd ? up_cd_ready : 1'b1);
  assign cr_hs     = cr_ready & cr_valid;
  assign ac_done_d = ac_done | (ac_valid & ac_ready);
  assign cr_done_d = cr_done | cr_hs;
  assign resp_d    = cr_hs ? cr_resp : resp_q;
  assign dt_d      = cr_hs ? cr_resp[0] : (dt & ~(cd_ready & cd_valid & cd_last));

  always_ff @(posedge clk_i) begin
    if (rst_i || clr) begin
      ac_done <= 1'b0;
      cr_done <= 1'b0;
      resp_q  <= '0;
      dt      <= 1'b0;
    end else begin
      ac_done <= ac_done_d;
      cr_done <= cr_done_d;
      resp_q  <= resp_d;
      dt      <= dt_d;
    end
  end
endmodule

module snoop_multicast #(
  parameter int NoMst     = 4,
  parameter int AddrWidth = 64,
  parameter int DataWidth = 64
) (
  input logic               clk_i,
  input logic               rst_i,
  snoop_multicast_if.slave  bus
);
  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] BCAST   = 3'd1;
  localparam logic [2:0] COLLECT = 3'd2;
  localparam logic [2:0] RESP    = 3'd3;
  localparam logic [2:0] DATA    = 3'd4;

  logic [2:0]            state_q, state_d;
  logic [AddrWidth-1:0]  addr_q;
  logic [2:0]            prot_q;
  logic [3:0]            snoop_q;
  logic [4:0]            resp_q, merged;
  logic [NoMst-1:0]      ac_done_d, cr_done_d, dt_q, dt_d, fwd_q, lowest;
  logic [NoMst-1:0][4:0] resp_d;
  logic                  ac_hs, cr_hs, in_bcast, in_collect, in_data;

  assign ac_hs      = (state_q == IDLE) & bus.slv_ac_valid_i;
  assign cr_hs      = (state_q == RESP) & bus.slv_cr_ready_i;
  assign in_bcast   = (state_q == BCAST);
  assign in_collect = (state_q == COLLECT);
  assign in_data    = (state_q == DATA);

  for (genvar i = 0; i < NoMst; i++) begin : g_lane
    snoop_multicast_lane u_lane (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .clr         (ac_hs),
      .in_bcast    (in_bcast),
      .in_collect  (in_collect),
      .in_data     (in_data),
      .fwd         (fwd_q[i]),
      .up_cd_ready (bus.slv_cd_ready_i),
      .ac_ready    (bus.mst_ac_ready_i[i]),
      .cr_valid    (bus.mst_cr_valid_i[i]),
      .cr_resp     (bus.mst_cr_resp_i[i]),
      .cd_valid    (bus.mst_cd_valid_i[i]),
      .cd_last     (bus.mst_cd_last_i[i]),
      .ac_valid    (bus.mst_ac_valid_o[i]),
      .cr_ready    (bus.mst_cr_ready_o[i]),
      .cd_ready    (bus.mst_cd_ready_o[i]),
      .ac_done_d   (ac_done_d[i]),
      .cr_done_d   (cr_done_d[i]),
      .dt          (dt_q[i]),
      .dt_d        (dt_d[i]),
      .resp_d      (resp_d[i])
    );
  end

  // Merge includes responses landing in the final COLLECT cycle
  always_comb begin
    merged = '0;
    lowest = '0;
    for (int i = NoMst - 1; i >= 0; i--) begin
      merged = merged | resp_d[i];
      if (dt_q[i]) begin
        lowest    = '0;
        lowest[i] = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.slv_ac_valid_i) state_d = BCAST;
      BCAST:   if (&ac_done_d)         state_d = COLLECT;
      COLLECT: if (&cr_done_d)         state_d = RESP;
      RESP:    if (cr_hs)              state_d = (|dt_q) ? DATA : IDLE;
      DATA:    if (~|dt_d)             state_d = IDLE;
      default:                         state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      addr_q  <= '0;
      prot_q  <= '0;
      snoop_q <= '0;
      resp_q  <= '0;
      fwd_q   <= '0;
    end else begin
      state_q <= state_d;
      if (ac_hs) begin
        addr_q  <= bus.slv_ac_addr_i;
        prot_q  <= bus.slv_ac_prot_i;
        snoop_q <= bus.slv_ac_snoop_i;
        resp_q  <= '0;
        fwd_q   <= '0;
      end
      if (in_collect && (&cr_done_d)) resp_q <= merged;
      // Forwarding lane is frozen at DATA entry so drains never take over
      if (cr_hs) fwd_q <= lowest;
    end
  end

  assign bus.slv_ac_ready_o = (state_q == IDLE);
  assign bus.slv_cr_valid_o = (state_q == RESP);
  assign bus.slv_cr_resp_o  = resp_q;
  assign bus.mst_ac_addr_o  = addr_q;
  assign bus.mst_ac_prot_o  = prot_q;
  assign bus.mst_ac_snoop_o = snoop_q;

  always_comb begin
    bus.slv_cd_valid_o = 1'b0;
    bus.slv_cd_data_o  = '0;
    bus.slv_cd_last_o  = 1'b0;
    for (int i = 0; i < NoMst; i++) begin
      if (in_data && fwd_q[i] && dt_q[i]) begin
        bus.slv_cd_valid_o = bus.mst_cd_valid_i[i];
        bus.slv_cd_data_o  = bus.mst_cd_data_i[i];
        bus.slv_cd_last_o  = bus.mst_cd_last_i[i];
      end
    end
  end
endmodule

// File: tb/tb_snoop_multicast.sv
// Directed-vector bench for snoop_multicast: a cycle-stepped cache model
// per lane plus an upstream scoreboard for CR/CD content and timing.
module tb_snoop_multicast;
  localparam int N  = 4;
  localparam int AW = 64;
  localparam int DW = 64;
  localparam int NV = 8;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  always #5 clk_i = ~clk_i;

  snoop_multicast_if #(.NoMst(N), .AddrWidth(AW), .DataWidth(DW)) bus ();
  snoop_multicast #(.NoMst(N), .AddrWidth(AW), .DataWidth(DW)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  typedef struct {
    logic [N-1:0][4:0] resp;
    logic [N-1:0][7:0] ac_dly;
    logic [N-1:0][7:0] cr_dly;
    logic [N-1:0]      junk;
    int                beats;
    bit                rnd;
    int                abort_at;
    logic [AW-1:0]     addr;
    logic [2:0]        prot;
    logic [3:0]        snoop;
    logic [4:0]        exp_resp;
    int                exp_sel;
  } vec_t;

  vec_t  vt [NV];
  int    checks = 0;
  int    failures = 0;
  string tag;
  bit    acc [N];
  bit    cr_sent [N];
  int    ac_cnt [N];
  int    cr_cnt [N];
  int    beat [N];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s %s: got %0h expected %0h", tag, nm, act, exp);
    end
  endtask

  function automatic logic [63:0] pat(input int i, input int b);
    logic [63:0] p;
    p = 64'hCAFE_0000_0000_0000;
    p[23:16] = 8'(i);
    p[7:0]   = 8'(b);
    return p;
  endfunction

  function automatic vec_t blank(input int k);
    vec_t v;
    v.resp     = '0;
    v.ac_dly   = '0;
    v.cr_dly   = '0;
    v.junk     = '0;
    v.beats    = 4;
    v.rnd      = 1'b0;
    v.abort_at = 0;
    v.addr     = 64'h0000_1234_8000_0000 | (64'(k) << 6);
    v.prot     = 3'(k);
    v.snoop    = 4'(k + 1);
    v.exp_resp = '0;
    v.exp_sel  = -1;
    return v;
  endfunction

  task automatic clear_inputs();
    bus.slv_ac_valid_i = 1'b0;
    bus.slv_ac_addr_i  = '0;
    bus.slv_ac_prot_i  = '0;
    bus.slv_ac_snoop_i = '0;
    bus.slv_cr_ready_i = 1'b0;
    bus.slv_cd_ready_i = 1'b0;
    bus.mst_ac_ready_i = '0;
    bus.mst_cr_resp_i  = '0;
    bus.mst_cr_valid_i = '0;
    bus.mst_cd_data_i  = '0;
    bus.mst_cd_last_i  = '0;
    bus.mst_cd_valid_i = '0;
  endtask

  task automatic check_reset(input string nm);
    tag = nm;
    chk("ac_ready", 128'(bus.slv_ac_ready_o), 128'(1));
    chk("hs_outs", 128'({bus.mst_ac_valid_o, bus.mst_cr_ready_o, bus.mst_cd_ready_o,
                         bus.slv_cr_valid_o, bus.slv_cd_valid_o}), 128'(0));
    chk("cr_resp", 128'(bus.slv_cr_resp_o), 128'(0));
    chk("ac_payload", 128'({bus.mst_ac_addr_o, bus.mst_ac_prot_o, bus.mst_ac_snoop_o}), 128'(0));
    chk("cd_payload", 128'({bus.slv_cd_data_o, bus.slv_cd_last_o}), 128'(0));
  endtask

  task automatic drive_caches(input vec_t v);
    for (int i = 0; i < N; i++) begin
      bus.mst_ac_ready_i[i] = !acc[i] && (ac_cnt[i] >= int'(v.ac_dly[i]));
      bus.mst_cr_valid_i[i] = acc[i] && !cr_sent[i] && (cr_cnt[i] >= int'(v.cr_dly[i]));
      bus.mst_cr_resp_i[i]  = v.resp[i];
      if (cr_sent[i] && v.resp[i][0] && beat[i] < v.beats) begin
        bus.mst_cd_valid_i[i] = 1'b1;
        bus.mst_cd_data_i[i]  = pat(i, beat[i]);
        bus.mst_cd_last_i[i]  = (beat[i] == v.beats - 1);
      end else if (v.junk[i]) begin
        bus.mst_cd_valid_i[i] = 1'b1;
        bus.mst_cd_data_i[i]  = 64'hBAD0_BAD0_BAD0_BAD0;
        bus.mst_cd_last_i[i]  = 1'b1;
      end else begin
        bus.mst_cd_valid_i[i] = 1'b0;
        bus.mst_cd_data_i[i]  = '0;
        bus.mst_cd_last_i[i]  = 1'b0;
      end
    end
    bus.slv_cr_ready_i = v.rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    bus.slv_cd_ready_i = v.rnd ? 1'($urandom_range(0, 1)) : 1'b1;
  endtask

  task automatic run_vec(input int k, output bit aborted);
    vec_t        v;
    int          cyc, ac_hs_cyc, first_acv, last_ac, first_crr, last_cr, first_crv;
    int          crs, up_beats, exp_beats;
    bit          cr_hold, cd_hold, post, dn;
    logic [4:0]  cr_held;
    logic [64:0] cd_held;
    v = vt[k];
    tag = $sformatf("v%0d", k);
    aborted = 1'b0;
    cyc = 0; ac_hs_cyc = -1; first_acv = -1; last_ac = -1;
    first_crr = -1; last_cr = -1; first_crv = -1;
    crs = 0; up_beats = 0; cr_hold = 0; cd_hold = 0; post = 0;
    cr_held = '0; cd_held = '0;
    exp_beats = (v.exp_sel >= 0) ? v.beats : 0;
    for (int i = 0; i < N; i++) begin
      acc[i] = 0; cr_sent[i] = 0; ac_cnt[i] = 0; cr_cnt[i] = 0; beat[i] = 0;
    end
    bus.slv_ac_addr_i  = v.addr;
    bus.slv_ac_prot_i  = v.prot;
    bus.slv_ac_snoop_i = v.snoop;
    bus.slv_ac_valid_i = 1'b1;
    drive_caches(v);
    while (1) begin
      @(negedge clk_i);
      if (bus.slv_ac_valid_i && bus.slv_ac_ready_o) ac_hs_cyc = cyc;
      if (first_crr < 0 && (|bus.mst_cr_ready_o)) first_crr = cyc;
      for (int i = 0; i < N; i++) begin
        if (acc[i] && !cr_sent[i]) begin
          if (bus.mst_cr_valid_i[i] && bus.mst_cr_ready_o[i]) begin
            cr_sent[i] = 1;
            last_cr = cyc;
          end else cr_cnt[i]++;
        end
        if (acc[i]) chk("ac_no_reassert", 128'(bus.mst_ac_valid_o[i]), 128'(0));
        else if (bus.mst_ac_valid_o[i]) begin
          if (first_acv < 0) begin
            first_acv = cyc;
            chk("ac_payload", 128'({bus.mst_ac_addr_o, bus.mst_ac_prot_o, bus.mst_ac_snoop_o}),
                128'({v.addr, v.prot, v.snoop}));
          end
          if (bus.mst_ac_ready_i[i]) begin
            acc[i] = 1;
            last_ac = cyc;
          end else ac_cnt[i]++;
        end
        if (v.junk[i] && !v.resp[i][0])
          chk("nodt_cd_ready", 128'(bus.mst_cd_ready_o[i]), 128'(0));
        if (bus.mst_cd_valid_i[i] && bus.mst_cd_ready_o[i] && v.resp[i][0] &&
            cr_sent[i] && beat[i] < v.beats)
          beat[i]++;
      end
      if (bus.slv_cr_valid_o) begin
        if (first_crv < 0) first_crv = cyc;
        if (cr_hold) chk("cr_stable", 128'(bus.slv_cr_resp_o), 128'(cr_held));
        if (bus.slv_cr_ready_i) begin
          chk("cr_resp", 128'(bus.slv_cr_resp_o), 128'(v.exp_resp));
          crs++;
          cr_hold = 0;
        end else begin
          cr_hold = 1;
          cr_held = bus.slv_cr_resp_o;
        end
      end else if (cr_hold) chk("cr_valid_held", 128'(bus.slv_cr_valid_o), 128'(1));
      if (bus.slv_cd_valid_o) begin
        if (cd_hold) chk("cd_stable", 128'({bus.slv_cd_data_o, bus.slv_cd_last_o}), 128'(cd_held));
        if (bus.slv_cd_ready_i) begin
          chk("cd_data", 128'({bus.slv_cd_data_o, bus.slv_cd_last_o}),
              128'({pat(v.exp_sel, up_beats), 1'(up_beats == v.beats - 1)}));
          up_beats++;
          cd_hold = 0;
        end else begin
          cd_hold = 1;
          cd_held = {bus.slv_cd_data_o, bus.slv_cd_last_o};
        end
      end else if (cd_hold) chk("cd_valid_held", 128'(bus.slv_cd_valid_o), 128'(1));
      if (v.abort_at > 0 && up_beats == v.abort_at) begin
        aborted = 1'b1;
        break;
      end
      if (post) begin
        chk("cr_count", 128'(crs), 128'(1));
        chk("cd_beats", 128'(up_beats), 128'(exp_beats));
        chk("back_idle", 128'(bus.slv_ac_ready_o), 128'(1));
        chk("lat_ac", 128'(first_acv - ac_hs_cyc), 128'(1));
        chk("lat_collect", 128'(first_crr - last_ac), 128'(1));
        chk("lat_cr", 128'(first_crv - last_cr), 128'(1));
        break;
      end
      dn = (crs > 0);
      for (int i = 0; i < N; i++)
        if (v.resp[i][0] && beat[i] < v.beats) dn = 0;
      if (v.exp_sel >= 0 && up_beats < v.beats) dn = 0;
      post = dn;
      if (cyc > 400) begin
        checks++;
        failures++;
        $display("FAIL %s timeout: crs=%0d beats=%0d", tag, crs, up_beats);
        break;
      end
      @(posedge clk_i);
      #1;
      cyc++;
      if (ac_hs_cyc >= 0) bus.slv_ac_valid_i = 1'b0;
      drive_caches(v);
    end
  endtask

  initial begin
    bit ab;
    for (int k = 0; k < NV; k++) vt[k] = blank(k);
    // v0/v1: nobody supplies data, back-to-back snoops
    // v2: cache 2 supplies, cache 0 shows stray CD valid without DataTransfer
    vt[2].resp[2] = 5'b01001; vt[2].junk = 4'b0001;
    vt[2].exp_resp = 5'b01001; vt[2].exp_sel = 2;
    // v3: two suppliers, lowest forwarded, other drained in the same cycles
    vt[3].resp[1] = 5'b00101; vt[3].resp[3] = 5'b00101;
    vt[3].exp_resp = 5'b00101; vt[3].exp_sel = 1;
    // v4: reverse AC acceptance, cache 0 CR late
    vt[4].ac_dly[0] = 8'd3; vt[4].ac_dly[1] = 8'd2; vt[4].ac_dly[2] = 8'd1;
    vt[4].cr_dly[0] = 8'd10; vt[4].resp[0] = 5'b01000; vt[4].exp_resp = 5'b01000;
    // v5: random upstream back-pressure
    vt[5].resp[0] = 5'b10001; vt[5].resp[3] = 5'b00011; vt[5].rnd = 1'b1;
    vt[5].exp_resp = 5'b10011; vt[5].exp_sel = 0;
    // v6: reset after two forwarded beats; v7 must then run cleanly
    vt[6].resp[2] = 5'b01001; vt[6].abort_at = 2;
    vt[6].exp_resp = 5'b01001; vt[6].exp_sel = 2;
    vt[7].resp[3] = 5'b00001; vt[7].beats = 3;
    vt[7].exp_resp = 5'b00001; vt[7].exp_sel = 3;

    clear_inputs();
    repeat (2) @(posedge clk_i);
    #1;
    check_reset("reset");
    rst_i = 1'b0;
    @(posedge clk_i);
    #1;
    for (int k = 0; k < NV; k++) begin
      run_vec(k, ab);
      if (ab) begin
        @(posedge clk_i);
        #1;
        rst_i = 1'b1;
        @(posedge clk_i);
        #1;
        check_reset("rst_mid");
        rst_i = 1'b0;
        clear_inputs();
      end
      @(posedge clk_i);
      #1;
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
